// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary to packed-BCD converter with saturation on overflow.
// Optional leading-zero blanking output is enabled by defining LEADING_ZERO_BLANK_EN.
module bin_to_bcd #(
  parameter int BIN_WIDTH  = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BIN_WIDTH-1:0]      binary_in,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [NUM_DIGITS*4-1:0]   bcd_value
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] BCD_MAX = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [63:0] BIN_MAX = (64'd1 << BIN_WIDTH) - 64'd1;
  // When every input value fits in the digit count, overflow is structurally impossible.
  localparam bit          CAN_OVF = (BIN_MAX > BCD_MAX);
  localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg;
  logic [BIN_WIDTH-1:0] bin_reg;
  logic [BCD_W-1:0]     scratch_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 ovf_pending_reg;

  logic [BCD_W-1:0]     adj_next;
  logic [BCD_W-1:0]     scratch_next;
  logic                 ovf_in;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign adj_next[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                   (scratch_reg[gi*4 +: 4] + 4'd3) :
                                   scratch_reg[gi*4 +: 4];
    end
  endgenerate

  // The bit shifted out of the top digit only matters on overflow, where the result saturates.
  assign scratch_next = BCD_W'({adj_next, bin_reg[BIN_WIDTH-1]});
  assign ovf_in       = CAN_OVF && (64'(binary_in) > BCD_MAX);

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_next;
  logic                  all_zero;

  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (scratch_reg[i*4 +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      bin_reg         <= '0;
      scratch_reg     <= '0;
      cnt_reg         <= '0;
      ovf_pending_reg <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      bcd_value       <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank           <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            bin_reg         <= binary_in;
            scratch_reg     <= '0;
            cnt_reg         <= CNT_W'(BIN_WIDTH);
            ovf_pending_reg <= ovf_in;
            state_reg       <= SHIFT;
            busy            <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end

        SHIFT: begin
          if (cnt_reg != '0) begin
            scratch_reg <= scratch_next;
            bin_reg     <= bin_reg << 1;
            cnt_reg     <= cnt_reg - 1'b1;
          end else begin
            // All bits consumed: publish the result together with the done pulse.
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            overflow  <= ovf_pending_reg;
            bcd_value <= ovf_pending_reg ? ALL_NINES : scratch_reg;
`ifdef LEADING_ZERO_BLANK_EN
            blank     <= ovf_pending_reg ? '0 : blank_next;
`endif
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench for bin_to_bcd: driver pushes expected results, a negedge monitor checks them.
// Build with LEADING_ZERO_BLANK_EN defined to also check the blank output.
module tb_bin_to_bcd;

  localparam int BW      = 20;
  localparam int ND      = 6;
  localparam int LATENCY = BW + 1;

  logic            clk;
  logic            reset;
  logic            start;
  logic [BW-1:0]   binary_in;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [ND*4-1:0] bcd_value;
`ifdef LEADING_ZERO_BLANK_EN
  logic [ND-1:0]   blank;
`endif

  bin_to_bcd #(.BIN_WIDTH(BW), .NUM_DIGITS(ND)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .binary_in (binary_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bcd_value (bcd_value)
`ifdef LEADING_ZERO_BLANK_EN
    ,
    .blank     (blank)
`endif
  );

  typedef struct {
    logic [BW-1:0]   value;
    logic [ND*4-1:0] bcd;
    bit              ovf;
    logic [ND-1:0]   blk;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding conversion.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 bcd=%h, required no done pulse", bcd_value);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bcd_value !== e.bcd) begin
          failures++;
          $display("FAIL bcd_value(%0d): got %h required %h", e.value, bcd_value, e.bcd);
        end
        checks++;
        if (overflow !== e.ovf) begin
          failures++;
          $display("FAIL overflow(%0d): got %b required %b", e.value, overflow, e.ovf);
        end
        checks++;
        if (cyc - e.cyc != LATENCY) begin
          failures++;
          $display("FAIL latency(%0d): got %0d cycles required %0d", e.value, cyc - e.cyc, LATENCY);
        end
`ifdef LEADING_ZERO_BLANK_EN
        checks++;
        if (blank !== e.blk) begin
          failures++;
          $display("FAIL blank(%0d): got %b required %b", e.value, blank, e.blk);
        end
`endif
        $display("conversion in=%0d bcd=%h ovf=%b latency=%0d", e.value, bcd_value, overflow, cyc - e.cyc);
      end
    end
  end

  task automatic check1(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  // Start a conversion and register its expected outcome with the scoreboard.
  task automatic issue(input logic [BW-1:0] v, input logic [ND*4-1:0] exp_bcd,
                       input bit exp_ovf, input logic [ND-1:0] exp_blk);
    exp_t x;
    start     = 1'b1;
    binary_in = v;
    @(posedge clk);
    #1;
    start   = 1'b0;
    x.value = v;
    x.bcd   = exp_bcd;
    x.ovf   = exp_ovf;
    x.blk   = exp_blk;
    x.cyc   = cyc;
    sb.push_back(x);
    check1("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: got no done within 60 cycles, required done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    binary_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_overflow", overflow, 1'b0);
    checks++;
    if (bcd_value !== '0) begin
      failures++;
      $display("FAIL reset_bcd: got %h required 000000", bcd_value);
    end
`ifdef LEADING_ZERO_BLANK_EN
    checks++;
    if (blank !== '0) begin
      failures++;
      $display("FAIL reset_blank: got %b required 000000", blank);
    end
`endif
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue(20'd123456, 24'h123456, 1'b0, 6'b000000);
    wait_done();
    check1("busy_in_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    issue(20'd42, 24'h000042, 1'b0, 6'b111100);
    wait_done();
    issue(20'd9050, 24'h009050, 1'b0, 6'b110000);
    wait_done();

    // Back-to-back: the second start lands while done is high.
    issue(20'd0, 24'h000000, 1'b0, 6'b111110);
    wait_done();
    issue(20'd999999, 24'h999999, 1'b0, 6'b000000);
    wait_done();

    issue(20'd1000000, 24'h999999, 1'b1, 6'b000000);
    wait_done();
    issue(20'd1048575, 24'h999999, 1'b1, 6'b000000);
    wait_done();
    repeat (2) @(posedge clk);
    #1;

    // A start during SHIFT must be ignored.
    issue(20'd654321, 24'h654321, 1'b0, 6'b000000);
    repeat (5) @(posedge clk);
    #1;
    start     = 1'b1;
    binary_in = 20'd42;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (30) @(posedge clk);
    #1;

    // Reset during the 10th SHIFT cycle aborts without a done pulse.
    start     = 1'b1;
    binary_in = 20'd777777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check1("busy_before_abort", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check1("abort_overflow", overflow, 1'b0);
    checks++;
    if (bcd_value !== '0) begin
      failures++;
      $display("FAIL abort_bcd: got %h required 000000", bcd_value);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;

    issue(20'd7, 24'h000007, 1'b0, 6'b111110);
    wait_done();
    repeat (3) @(posedge clk);
    #1;

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
